adc_spi_responder: RTL

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_resp_pkg.sv | 25 ++
 rtl/adc_resp_sync.sv | 37 +++
 rtl/adc_spi_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/adc_resp_pkg.sv
// Shared constants, FSM state type and small helpers for the ADC128S022
// responder model.
package adc_resp_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int LEAD_ZEROS     = 4;
  localparam int DATA_W         = 12;
  localparam int NUM_CH         = 8;
  localparam int ADDR_FIRST_BIT = 2;

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } resp_state_e;

  // True on the rising-edge indices that carry the channel address bits.
  function automatic logic is_addr_edge(input logic [CNT_W-1:0] cnt);
    return (int'(cnt) >= ADDR_FIRST_BIT) && (int'(cnt) < ADDR_FIRST_BIT + CH_W);
  endfunction

endpackage

// File: rtl/adc_resp_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, plus a third flop so
// rising/falling edges of the synchronized level can be flagged as
// single-cycle pulses. IDLE_LVL is the level the chain resets to, so that
// reset itself never manufactures an edge on an idle line.
module adc_resp_sync #(
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic clk,
  input  logic srst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Synchronizer chain with one extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= IDLE_LVL;
      sync_reg <= IDLE_LVL;
      prev_reg <= IDLE_LVL;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign rise  = sync_reg & ~prev_reg;
  assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC128S022 slave emulator. The master clocks 16-bit frames; each frame
// returns {4'b0, table[ch]} MSB first, where ch is the address the master
// sent in the previous frame (data lags the address by one frame).
// Optional build macro: ADC_RESP_TRISTATE_EN -- spi_dout floats while idle.
module adc_spi_responder
  import adc_resp_pkg::*;
#(
  parameter int SCLK_MIN_HALF = 3
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_din,
  output logic              spi_dout,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic [CH_W-1:0]   frame_ch
);

  // Edges are acted on three cycles after the pin moves, so a shorter
  // SCLK half-period would let DOUT change after the master samples it.
  if (SCLK_MIN_HALF < 3) begin : g_bad_min_half
    $error("SCLK_MIN_HALF must be at least the 3-cycle input latency");
  end

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  // ---------------------------------------------------------------- inputs
  logic unused_sclk_level, sclk_rise, sclk_fall;
  logic unused_cs_level, cs_rise, cs_fall;
  logic din_meta_reg, din_sync_reg;

  adc_resp_sync #(.IDLE_LVL(1'b1)) u_sync_sclk (
    .clk      (clk_50),
    .srst     (reset),
    .async_in (spi_sclk),
    .level    (unused_sclk_level),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  adc_resp_sync #(.IDLE_LVL(1'b1)) u_sync_cs (
    .clk      (clk_50),
    .srst     (reset),
    .async_in (spi_cs_n),
    .level    (unused_cs_level),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // Address line only needs a level; two flops keep it aligned with the
  // synchronized SCLK so it is stable when the rising-edge pulse fires.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      din_meta_reg <= 1'b0;
      din_sync_reg <= 1'b0;
    end else begin
      din_meta_reg <= spi_din;
      din_sync_reg <= din_meta_reg;
    end
  end

  // ---------------------------------------------------------- value table
  logic [DATA_W-1:0] tbl_mem [NUM_CH];
  logic [NUM_CH-1:0] tbl_wr_sel;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_wr_dec
    assign tbl_wr_sel[gi] = wr_en && (wr_ch == CH_W'(gi));
  end

  // Table storage; the read happens in LOAD straight into the shift
  // register, so a same-cycle write is only seen by the following frame.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) tbl_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (tbl_wr_sel[i]) tbl_mem[i] <= wr_data;
      end
    end
  end

  // ------------------------------------------------------------------ FSM
  resp_state_e           state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [CH_W-1:0]       addr_reg, addr_next;
  logic [CH_W-1:0]       next_ch_reg, next_ch_next;
  logic [CH_W-1:0]       cur_ch_reg, cur_ch_next;
  logic [CH_W-1:0]       frame_ch_reg, frame_ch_next;
  logic                  frame_done_reg, frame_done_next;
  logic [FRAME_BITS-1:0] sr_reg, sr_next;

  // State and datapath registers.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      next_ch_reg    <= '0;
      cur_ch_reg     <= '0;
      frame_ch_reg   <= '0;
      frame_done_reg <= 1'b0;
      sr_reg         <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      addr_reg       <= addr_next;
      next_ch_reg    <= next_ch_next;
      cur_ch_reg     <= cur_ch_next;
      frame_ch_reg   <= frame_ch_next;
      frame_done_reg <= frame_done_next;
      sr_reg         <= sr_next;
    end
  end

  // Next-state and datapath update from synchronized SPI edges.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    addr_next       = addr_reg;
    next_ch_next    = next_ch_reg;
    cur_ch_next     = cur_ch_reg;
    frame_ch_next   = frame_ch_reg;
    frame_done_next = 1'b0;
    sr_next         = sr_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cs_fall) state_next = ST_LOAD;
      end

      ST_LOAD: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          sr_next    = '0;
          cnt_next   = '0;
        end else begin
          sr_next     = {{LEAD_ZEROS{1'b0}}, tbl_mem[next_ch_reg]};
          cur_ch_next = next_ch_reg;
          cnt_next    = '0;
          state_next  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          sr_next    = '0;
          cnt_next   = '0;
        end else begin
          // The fall before rising edge 0 must not shift: bit 15 has not
          // been sampled yet.
          if (sclk_fall && (cnt_reg != '0)) begin
            sr_next = {sr_reg[FRAME_BITS-2:0], 1'b0};
          end
          if (sclk_rise) begin
            if (is_addr_edge(cnt_reg)) begin
              addr_next = {addr_reg[CH_W-2:0], din_sync_reg};
            end
            if (cnt_reg == LAST_BIT) begin
              frame_done_next = 1'b1;
              frame_ch_next   = cur_ch_reg;
              next_ch_next    = addr_reg;
              cnt_next        = '0;
              state_next      = ST_LOAD;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Bit 15 of every loaded word is a leading zero, so driving 0 outside
  // SHIFT matches the freshly loaded MSB during LOAD.
  logic dout_bit;
  assign dout_bit = (state_reg == ST_SHIFT) ? sr_reg[FRAME_BITS-1] : 1'b0;

`ifdef ADC_RESP_TRISTATE_EN
  assign spi_dout = (state_reg == ST_IDLE) ? 1'bz : dout_bit;
`else
  assign spi_dout = dout_bit;
`endif

  assign frame_done = frame_done_reg;
  assign frame_ch   = frame_ch_reg;

endmodule
